// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR card generator: FSM states, default
// maximal-length Galois masks and the single-step LFSR function.
package lfsr_pkg;

  // Draw controller states
  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } draw_state_e;

  // Widest LFSR the shared step function supports
  localparam int unsigned MAX_WIDTH = 32;

  // Right-shifting Galois masks giving maximal-length sequences
  localparam logic [3:0]  TAPS_W4  = 4'hC;
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

  // One Galois step on a zero-extended state; callers truncate to their width
  function automatic logic [MAX_WIDTH-1:0] galois_step(
    input logic [MAX_WIDTH-1:0] state,
    input logic [MAX_WIDTH-1:0] taps
  );
    if (state[0]) begin
      return (state >> 1) ^ taps;
    end
    return state >> 1;
  endfunction

endpackage

// File: rtl/lfsr_card_gen_if.sv
// Request/seed/result bundle between the puzzle dealer and the card generator.
interface lfsr_card_gen_if #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned NUM_CARDS = 4,
  parameter int unsigned CARD_W    = 4
);

  logic                        seed_load;
  logic [WIDTH-1:0]            seed_in;
  logic                        req;
  logic                        busy;
  logic                        valid;
  logic [NUM_CARDS*CARD_W-1:0] cards;
  logic [WIDTH-1:0]            lfsr_state;

  // Dealer side: issues requests and seeds, consumes hands
  modport master (
    output seed_load, seed_in, req,
    input  busy, valid, cards, lfsr_state
  );

  // Generator side
  modport slave (
    input  seed_load, seed_in, req,
    output busy, valid, cards, lfsr_state
  );

endinterface

// File: rtl/lfsr_galois.sv
// Free-running Galois LFSR with seed load and recovery from the all-zero
// lock-up state.
module lfsr_galois
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load_i,
  input  logic [WIDTH-1:0] seed_in_i,
  output logic [WIDTH-1:0] state_o
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;

  // Next state: a seed load wins, a zero seed or a locked-up register falls back to SEED
  always_comb begin
    state_d = WIDTH'(galois_step(MAX_WIDTH'(state_q), MAX_WIDTH'(TAPS)));
    if (seed_load_i) begin
      state_d = (seed_in_i != '0) ? seed_in_i : SEED;
    end else if (state_q == '0) begin
      state_d = SEED;
    end
  end

  // State register, restarts from SEED on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/lfsr_card_gen.sv
// Card hand generator: draws NUM_CARDS values in 1..CARD_MAX from the low
// bits of a Galois LFSR by rejection sampling and publishes them as one
// packed hand with a single-cycle valid pulse.
module lfsr_card_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
  parameter logic [WIDTH-1:0] SEED      = 16'hACE1,
  parameter int unsigned      NUM_CARDS = 4,
  parameter int unsigned      CARD_W    = 4,
  parameter int unsigned      CARD_MAX  = 13
) (
  input  logic          clk,
  input  logic          rst,
  lfsr_card_gen_if.slave bus
);

  localparam int unsigned IDX_W   = $clog2(NUM_CARDS + 1);
  localparam int unsigned CARDS_W = NUM_CARDS * CARD_W;
  localparam logic [CARD_W-1:0] CARD_MAX_C = CARD_W'(CARD_MAX);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_CARDS - 1);

  if (CARD_W > WIDTH) begin : gBadCardW
    $error("lfsr_card_gen: CARD_W must not exceed WIDTH");
  end
  if (WIDTH > MAX_WIDTH) begin : gBadWidth
    $error("lfsr_card_gen: WIDTH exceeds the supported maximum");
  end
  if (SEED == '0) begin : gBadSeed
    $error("lfsr_card_gen: SEED must be non-zero");
  end
  if ((CARD_MAX == 0) || (CARD_MAX > (2 ** CARD_W) - 1)) begin : gBadCardMax
    $error("lfsr_card_gen: CARD_MAX out of range for CARD_W");
  end

  logic [WIDTH-1:0]   lfsrState;
  logic [CARD_W-1:0]  cand;
  logic               candOk;

  draw_state_e        state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CARDS_W-1:0] workBuf_q, workBuf_d;
  logic [CARDS_W-1:0] cards_q, cards_d;
  logic               valid_q, valid_d;

  lfsr_galois #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) uLfsr (
    .clk         (clk),
    .rst         (rst),
    .seed_load_i (bus.seed_load),
    .seed_in_i   (bus.seed_in),
    .state_o     (lfsrState)
  );

  // The candidate is the pre-step register value, so a same-edge seed load cannot affect it
  assign cand   = lfsrState[CARD_W-1:0];
  assign candOk = (cand != '0) && (cand <= CARD_MAX_C);

  // Draw controller: accept in-range candidates into the working buffer, publish on the last slot
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    workBuf_d = workBuf_q;
    cards_d   = cards_q;
    valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          state_d = DRAW;
          idx_d   = '0;
        end
      end
      DRAW: begin
        if (candOk) begin
          for (int k = 0; k < NUM_CARDS; k++) begin
            if (idx_q == IDX_W'(k)) begin
              workBuf_d[k*CARD_W +: CARD_W] = cand;
            end
          end
          if (idx_q == LAST_IDX) begin
            cards_d = workBuf_d;
            valid_d = 1'b1;
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller registers; reset abandons any draw in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      workBuf_q <= '0;
      cards_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      workBuf_q <= workBuf_d;
      cards_q   <= cards_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.busy       = (state_q == DRAW);
  assign bus.valid      = valid_q;
  assign bus.cards      = cards_q;
  assign bus.lfsr_state = lfsrState;

endmodule
